// File: rtl/walk_request.sv
// walk_request: pedestrian front end for the crossing light controller.
// Synchronizes and debounces the raw push-button, gates the request until the
// vehicle green has been up long enough, holds btn_req until the controller
// leaves green, drives the WAIT lamp and counts serviced crossings.
//
// Handshake with the controller: btn_req is a level request. Once raised it is
// held until green_in falls (the controller's acknowledge). It is only ever
// raised while green_in is high.
module walk_request #(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int MIN_GREEN_CYCLES = 1000,
    parameter int AGE_W            = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_raw,
    input  logic       green_in,
    output logic       btn_req,
    output logic       wait_lamp,
    output logic [7:0] req_count,
    output logic       busy
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MIN_GREEN_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PENDING  = 2'd1,
        S_ASSERT   = 2'd2,
        S_SERVICED = 2'd3
    } state_t;

    logic                   rst_sync_q;
    logic                   rst_n_int;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_btn;
    logic                   stable_q, stable_d;
    logic                   stable_prev_q;
    logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
    logic                   press;
    logic [AGE_W-1:0]       age_q, age_d;
    logic                   age_ok;
    state_t                 state_q, state_d;
    logic [7:0]             count_q, count_d;
    logic                   btn_req_q, wait_q, busy_q;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end

    assign rst_n_int = rst_sync_q;

    // Metastability chain for the asynchronous pad input.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) sync_q <= '0;
        else            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end

    assign sync_btn = sync_q[SYNC_STAGES-1];

    // Debounce: count consecutive disagreeing cycles, flip after enough of them.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync_btn != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = ~stable_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Debounced level, its previous value and the run-length counter.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
        end
    end

    // Only the debounced rising edge is an event; release is ignored.
    assign press = stable_q & ~stable_prev_q;

    // Green age: how long vehicle green has been continuously on, saturating.
    always_comb begin
        age_d = age_q;
        if (!green_in)             age_d = '0;
        else if (age_q != AGE_MAX) age_d = age_q + 1'b1;
    end

    // Green age register.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) age_q <= '0;
        else            age_q <= age_d;
    end

    assign age_ok = (age_q == AGE_MAX);

    // Next state and serviced-crossing count. A green drop wins over age_ok
    // so the request can never be raised after the controller left green.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (press && green_in) state_d = S_PENDING;
            end
            S_PENDING: begin
                if (!green_in)   state_d = S_SERVICED;
                else if (age_ok) state_d = S_ASSERT;
            end
            S_ASSERT: begin
                if (!green_in) begin
                    state_d = S_SERVICED;
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                end
            end
            S_SERVICED: begin
                if (green_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, count and registered outputs decoded from the next state.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= S_IDLE;
            count_q   <= 8'd0;
            btn_req_q <= 1'b0;
            wait_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            btn_req_q <= (state_d == S_ASSERT);
            wait_q    <= (state_d == S_PENDING) || (state_d == S_ASSERT);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign btn_req   = btn_req_q;
    assign wait_lamp = wait_q;
    assign req_count = count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_walk_request.sv
// Directed bench for walk_request. Cycle n means "just after rising edge n",
// where edge 0 is the first edge after reset_n is released. A second instance
// with a short green gate exercises coalescing, saturation and mid-request reset.
module tb_walk_request;

    logic       clock = 1'b0;
    logic       rst_n, btn_raw, green_in;
    logic       btn_req, wait_lamp, busy;
    logic [7:0] req_count;

    logic       s_rst_n, s_btn_raw, s_green;
    logic       s_btn_req, s_wait, s_busy;
    logic [7:0] s_count;

    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int s_pulses = 0;
    logic s_req_prev = 1'b0;
    int pulse_base;

    walk_request dut (
        .clock(clock), .reset_n(rst_n), .btn_raw(btn_raw), .green_in(green_in),
        .btn_req(btn_req), .wait_lamp(wait_lamp), .req_count(req_count), .busy(busy)
    );

    walk_request #(.MIN_GREEN_CYCLES(4), .AGE_W(4)) dut_s (
        .clock(clock), .reset_n(s_rst_n), .btn_raw(s_btn_raw), .green_in(s_green),
        .btn_req(s_btn_req), .wait_lamp(s_wait), .req_count(s_count), .busy(s_busy)
    );

    // clock / reset block
    always #5 clock = ~clock;

    // Rising edges of the second instance's request.
    always @(posedge clock) begin
        s_req_prev <= s_btn_req;
        if (s_btn_req && !s_req_prev) s_pulses <= s_pulses + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        exp = 16'hDEAD;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_main();
        rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        push(0); push(0); push(0); push(0);
        check("rst_btn_req", {15'd0, btn_req});
        check("rst_wait", {15'd0, wait_lamp});
        check("rst_count", {8'd0, req_count});
        check("rst_busy", {15'd0, busy});
        rst_n = 1'b1;
        tick();
        cyc = 0;
    endtask

    task automatic wait_s_req(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!s_btn_req && n < max_cyc) begin
            tick();
            n++;
        end
        push(1);
        check(tag, {15'd0, s_btn_req});
    endtask

    // One full crossing on the second instance: press, request, green drop, green back.
    task automatic s_crossing(input string tag);
        s_btn_raw = 1'b1;
        wait_s_req(tag, 60);
        s_btn_raw = 1'b0;
        repeat (25) tick();
        s_green = 1'b0;
        repeat (2) tick();
        s_green = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        btn_raw = 1'b1; green_in = 1'b1;
        s_rst_n = 1'b0; s_btn_raw = 1'b0; s_green = 1'b1;

        // Button held through reset, green gate releases the request.
        reset_main();
        push(0); run_to(18); check("t1_wait_18", {15'd0, wait_lamp});
        push(1); push(1); run_to(19);
        check("t1_wait_19", {15'd0, wait_lamp});
        check("t1_busy_19", {15'd0, busy});
        push(0); run_to(1000); check("t1_req_1000", {15'd0, btn_req});
        push(1); run_to(1001); check("t1_req_1001", {15'd0, btn_req});
        push(1); push(1); run_to(1500);
        check("t1_req_1500", {15'd0, btn_req});
        check("t1_wait_1500", {15'd0, wait_lamp});
        green_in = 1'b0;
        push(0); push(0); push(1);
        run_to(1501);
        check("t1_req_1501", {15'd0, btn_req});
        check("t1_wait_1501", {15'd0, wait_lamp});
        check("t1_count_1501", {8'd0, req_count});
        run_to(1600); green_in = 1'b1;
        push(0); run_to(1601); check("t1_busy_1601", {15'd0, busy});
        push(0); push(0); push(1); run_to(2000);
        check("t1_busy_2000", {15'd0, busy});
        check("t1_req_2000", {15'd0, btn_req});
        check("t1_count_2000", {8'd0, req_count});
        btn_raw = 1'b0;

        // Bounce: toggle every 5 cycles for 100 cycles, never accepted.
        reset_main();
        for (int i = 0; i < 100; i++) begin
            btn_raw = ((i / 5) % 2 == 0);
            push(0);
            tick();
            check("t2_busy", {15'd0, busy});
        end
        btn_raw = 1'b0;
        push(0); push(0); push(0);
        run_to(140);
        check("t2_req", {15'd0, btn_req});
        check("t2_wait", {15'd0, wait_lamp});
        check("t2_count", {8'd0, req_count});

        // Age already met, clean press at relative cycle 0.
        run_to(1010);
        cyc = 0;
        btn_raw = 1'b1;
        push(0); push(1); push(0); push(1);
        run_to(18); check("t3_wait_18", {15'd0, wait_lamp});
        run_to(19); check("t3_wait_19", {15'd0, wait_lamp});
        check("t3_req_19", {15'd0, btn_req});
        run_to(20); check("t3_req_20", {15'd0, btn_req});
        run_to(22); btn_raw = 1'b0;
        run_to(30); green_in = 1'b0;
        push(0); push(1); push(1);
        run_to(31);
        check("t3_req_31", {15'd0, btn_req});
        check("t3_count_31", {8'd0, req_count});
        check("t3_busy_31", {15'd0, busy});
        run_to(2230); green_in = 1'b1;
        push(1); push(0);
        check("t3_busy_2230", {15'd0, busy});
        run_to(2231); check("t3_busy_2231", {15'd0, busy});

        // Press while green is already off: ignored.
        run_to(2240); green_in = 1'b0;
        btn_raw = 1'b1;
        push(0); push(0); push(0); push(1);
        run_to(2290);
        check("t5_busy", {15'd0, busy});
        check("t5_wait", {15'd0, wait_lamp});
        check("t5_req", {15'd0, btn_req});
        check("t5_count", {8'd0, req_count});
        btn_raw = 1'b0; green_in = 1'b1;

        // Coalescing on the short-gate instance: extra presses during one crossing.
        s_rst_n = 1'b1;
        repeat (10) tick();
        pulse_base = s_pulses;
        s_btn_raw = 1'b1;
        wait_s_req("t4_first_req", 60);
        for (int k = 0; k < 2; k++) begin
            s_btn_raw = 1'b0; repeat (25) tick();
            s_btn_raw = 1'b1; repeat (25) tick();
        end
        s_btn_raw = 1'b0; repeat (25) tick();
        push(1); check("t4_req_held", {15'd0, s_btn_req});
        s_green = 1'b0;
        repeat (3) tick();
        push(0); push(1);
        check("t4_req_off", {15'd0, s_btn_req});
        check("t4_count_svc", {8'd0, s_count});
        s_btn_raw = 1'b1; repeat (25) tick();
        s_btn_raw = 1'b0; repeat (25) tick();
        s_green = 1'b1;
        repeat (3) tick();
        push(0); push(1); push(1);
        check("t4_busy", {15'd0, s_busy});
        check("t4_pulses", 16'(s_pulses - pulse_base));
        check("t4_count", {8'd0, s_count});

        // Saturation: 256 crossings after a fresh reset.
        s_rst_n = 1'b0; tick(); s_rst_n = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < 256; i++) begin
            s_crossing("t6_req_seen");
            if (i == 0)   begin push(1);   check("t6_count_1", {8'd0, s_count}); end
            if (i == 254) begin push(255); check("t6_count_255", {8'd0, s_count}); end
            if (i == 255) begin push(255); check("t6_count_sat", {8'd0, s_count}); end
        end

        // Reset mid-request drops btn_req and clears the count at once.
        s_btn_raw = 1'b1;
        wait_s_req("t7_req_up", 60);
        s_rst_n = 1'b0;
        #1;
        push(0); push(0); push(0); push(0);
        check("t7_req_rst", {15'd0, s_btn_req});
        check("t7_count_rst", {8'd0, s_count});
        check("t7_wait_rst", {15'd0, s_wait});
        check("t7_busy_rst", {15'd0, s_busy});
        s_btn_raw = 1'b0;
        repeat (3) tick();

        // final report
        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
